filter_scheduler: RTL
=====================

# filter_scheduler

Frame-aligned controller for the pixel filter bank (mosaic and sibling filters). It accepts timed filter requests from the game logic (for example "mosaic for 30 frames after a dice roll"). It switches the one-hot filter enables only on frame boundaries, so no filter is ever enabled or disabled mid-frame. It sits between the game FSM and the filter datapath and drives each filter's `filter_en`.

## Interface
- `NUM_FILTERS`, 4: number of filters controlled; width of `filter_en`.
- `SEL_W`, `$clog2(NUM_FILTERS)`: width of the filter index.
- `FRAME_CNT_W`, 8: width of the frame duration counter.

- `clk` input 1: system clock (one clock domain).
- `reset` input 1: synchronous, active-high reset.
- `frame_start` input 1: one-cycle pulse at the start of each frame (first pixel of the frame not yet output).
- `req_valid` input 1: filter request valid.
- `req_filter` input SEL_W: requested filter index.
- `req_frames` input FRAME_CNT_W: duration in frames; 0 means persistent until `cancel`.
- `req_ready` output 1: request accepted when `req_valid && req_ready`; combinational.
- `cancel` input 1: level, sampled each cycle; ends the current or pending filter.
- `filter_en` output NUM_FILTERS: one-hot (or all-zero) enable to the filter bank; registered.
- `filter_sel` output SEL_W: index of the active filter; registered; 0 when idle.
- `frames_left` output FRAME_CNT_W: remaining frames including the current one; 0 when idle or persistent.
- `busy` output 1: high when the state is not IDLE.

## Operation
- States: IDLE, ARMED, ACTIVE, DRAIN.
- **IDLE**
  - `filter_en`=0.
  - An accepted request latches `req_filter` and `req_frames`, then moves to ARMED.
- **ARMED**
  - On `frame_start`: `filter_en` becomes one-hot of the latched index, `filter_sel` takes the latched index, `frames_left` takes the latched frames, then moves to ACTIVE.
  - `cancel` moves to IDLE immediately; nothing was ever enabled.
- **ACTIVE**
  - On `frame_start` with `frames_left`==1: `filter_en`=0, `filter_sel`=0, `frames_left`=0, then moves to IDLE.
  - On `frame_start` with `frames_left`>1: decrement `frames_left`.
  - When persistent (`frames_left`==0), the count holds.
  - `cancel` moves to DRAIN.
- **DRAIN**
  - Filter stays on until the next `frame_start`, which clears the outputs and moves to IDLE.
  - `req_ready`=0.
- `req_ready` = (state==IDLE) && !cancel, extended by the configuration macro below.
- Priorities, for simultaneous events:
  - `cancel` beats `req_valid`: no accept.
  - `cancel` together with `frame_start` in ACTIVE: outputs clear at that boundary, then IDLE (DRAIN is skipped).
  - Expiry `frame_start` together with an accept in ACTIVE (preempt build): the filter turns off at this boundary, the new request is latched, then ARMED.
  - `frame_start` together with an accept in IDLE: the request goes to ARMED and waits for the next `frame_start`. The same-cycle boundary is not used.
- `req_filter` ≥ NUM_FILTERS: accepted, but `filter_en` stays all-zero for the duration. Timing and state sequencing are unchanged.
- Frame arithmetic is unsigned FRAME_CNT_W. There is no wrap: decrement happens only when `frames_left`>1.
- `reset` mid-operation returns to IDLE the next cycle. No pending request survives reset.

## Timing
- Reset values:
  - state IDLE.
  - `filter_en`=0, `filter_sel`=0, `frames_left`=0, `busy`=0.
  - `req_ready`=1 (when `cancel` is low).
- `frame_start` in cycle t changes `filter_en`, `filter_sel` and `frames_left` at t+1 (registered). The pixel pipeline is guaranteed at least one idle cycle after `frame_start`.
- Accept in cycle t gives `busy`=1 at t+1.
- A request of N≥1 frames is enabled for exactly N consecutive full frames.
- `req_ready` depends on state and `cancel` only, never on `req_valid` (no combinational loop).

## Configuration
- `FILTER_SCHED_PREEMPT_EN` defined:
  - `req_ready` is also high in ACTIVE (when `!cancel`).
  - An accept in ACTIVE latches the new request and moves to ARMED.
  - The old filter stays enabled until the next `frame_start`, then switches directly to the new one-hot value with no all-zero frame in between.
  - `frames_left` reloads at that boundary.
- Not defined: `req_ready` is high only in IDLE. Requests during ARMED, ACTIVE or DRAIN are back-pressured.

## Test plan
- Basic run: reset, accept filter 2 for 3 frames, then 4 `frame_start` pulses.
  - `filter_en`=4'b0100 from the cycle after the 1st pulse until the cycle after the 4th pulse, then 0.
  - `frames_left` sequence 3, 2, 1, 0.
- Persistent run: request filter 1 with `req_frames`=0, 10 frames, then assert `cancel` mid-frame.
  - `filter_en`=4'b0010 throughout.
  - DRAIN, then 0 after the next `frame_start`; `busy`=0.
- Cancel while ARMED: accept, then `cancel` before any `frame_start`.
  - IDLE next cycle; `filter_en` never leaves 0.
- Simultaneous events:
  - `cancel` with `req_valid` in IDLE: no accept, `busy` stays 0.
  - `cancel` with `frame_start` in ACTIVE: `filter_en`=0 at t+1.
- Preempt (macro on): filter 0 active, `frames_left`=5, accept filter 3 for 2 frames.
  - 4'b0001 until the next `frame_start`, then 4'b1000 for 2 frames, then 0.
  - Macro off: same stimulus sees `req_ready`=0 and filter 0 runs its full 5 frames.
- Reset mid-ACTIVE: all outputs at reset values at t+1; a subsequent `frame_start` enables nothing.

Source files
------------

// File: rtl/filter_scheduler_if.sv
// Purpose : request channel from the game FSM into filter_scheduler.
// Latency : none, wires only.
// Backpressure: req_ready is driven by the scheduler; a request transfers on req_valid && req_ready.
//
// Signals:
//   req_valid  - requester has a filter request
//   req_ready  - scheduler can take a request this cycle
//   req_filter - filter index (SEL_W bits)
//   req_frames - duration in frames, 0 = persistent until cancel
interface filter_scheduler_if #(
   parameter int SEL_W       = 2,
   parameter int FRAME_CNT_W = 8
);
   logic                   req_valid;
   logic                   req_ready;
   logic [SEL_W-1:0]       req_filter;
   logic [FRAME_CNT_W-1:0] req_frames;

   modport master (
      output req_valid,
      output req_filter,
      output req_frames,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_filter,
      input  req_frames,
      output req_ready
   );
endinterface

// File: rtl/filter_scheduler.sv
// Purpose : frame-aligned one-hot enable controller for the pixel filter bank.
// Latency : frame_start at cycle t updates filter_en/filter_sel/frames_left at t+1.
// Backpressure: req_ready (combinational on state and cancel) is high in IDLE, and also in
//               ACTIVE when FILTER_SCHED_PREEMPT_EN is defined; low whenever cancel is high.
//
// Optional feature macro: FILTER_SCHED_PREEMPT_EN (requests may preempt a running filter).
//
// Ports:
//   clk, reset   - single clock, synchronous active-high reset
//   frame_start  - one-cycle pulse at the start of each frame
//   cancel       - level; ends the current or pending filter
//   req          - request channel (filter_scheduler_if.slave)
//   filter_en    - registered one-hot (or zero) enable to the filter bank
//   filter_sel   - registered index of the active filter, 0 when idle
//   frames_left  - frames remaining including the current one, 0 when idle or persistent
//   busy         - state is not IDLE
module filter_scheduler #(
   parameter int NUM_FILTERS = 4,
   parameter int SEL_W       = $clog2(NUM_FILTERS),
   parameter int FRAME_CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   frame_start,
   input  logic                   cancel,
   filter_scheduler_if.slave      req,
   output logic [NUM_FILTERS-1:0] filter_en,
   output logic [SEL_W-1:0]       filter_sel,
   output logic [FRAME_CNT_W-1:0] frames_left,
   output logic                   busy
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ARMED  = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;
   localparam logic [1:0] ST_DRAIN  = 2'd3;

   logic [1:0]             state;
   logic [SEL_W-1:0]       lat_filter;
   logic [FRAME_CNT_W-1:0] lat_frames;
   // ARMED was entered by preemption: the previous filter is still driving filter_en
   // and must not be dropped mid-frame.
   logic                   old_on;
   logic                   accept;
   logic                   expire;

   // Out-of-range indices match no bit, so the bank sees all-zero for that request.
   function automatic logic [NUM_FILTERS-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [NUM_FILTERS-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_FILTERS; i++) begin
         if (SEL_W'(i) == idx) begin
            v[i] = 1'b1;
         end
      end
      return v;
   endfunction

`ifdef FILTER_SCHED_PREEMPT_EN
   assign req.req_ready = !cancel && ((state == ST_IDLE) || (state == ST_ACTIVE));
`else
   assign req.req_ready = !cancel && (state == ST_IDLE);
`endif

   assign accept = req.req_valid && req.req_ready;
   // Boundary at which the running filter turns off (count reached its last frame, or cancelled).
   assign expire = frame_start && (cancel || (frames_left == FRAME_CNT_W'(1)));
   assign busy   = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         lat_filter  <= '0;
         lat_frames  <= '0;
         old_on      <= 1'b0;
         filter_en   <= '0;
         filter_sel  <= '0;
         frames_left <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               // A same-cycle frame_start is deliberately ignored: the request waits
               // for the next boundary so it always gets full frames.
               if (accept) begin
                  lat_filter <= req.req_filter;
                  lat_frames <= req.req_frames;
                  state      <= ST_ARMED;
               end
            end

            ST_ARMED: begin
               if (cancel) begin
                  old_on <= 1'b0;
                  if (old_on && !frame_start) begin
                     // Preempted filter is still on: let it finish this frame.
                     state <= ST_DRAIN;
                  end else begin
                     filter_en   <= '0;
                     filter_sel  <= '0;
                     frames_left <= '0;
                     state       <= ST_IDLE;
                  end
               end else if (frame_start) begin
                  // Switches straight to the new one-hot value, no all-zero frame.
                  filter_en   <= onehot(lat_filter);
                  filter_sel  <= lat_filter;
                  frames_left <= lat_frames;
                  old_on      <= 1'b0;
                  state       <= ST_ACTIVE;
               end
            end

            ST_ACTIVE: begin
               if (expire) begin
                  filter_en   <= '0;
                  filter_sel  <= '0;
                  frames_left <= '0;
                  if (accept) begin
                     lat_filter <= req.req_filter;
                     lat_frames <= req.req_frames;
                     state      <= ST_ARMED;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else if (cancel) begin
                  state <= ST_DRAIN;
               end else begin
                  // frames_left==0 is persistent and holds; no wrap below 1.
                  if (frame_start && (frames_left > FRAME_CNT_W'(1))) begin
                     frames_left <= frames_left - 1'b1;
                  end
                  if (accept) begin
                     lat_filter <= req.req_filter;
                     lat_frames <= req.req_frames;
                     old_on     <= 1'b1;
                     state      <= ST_ARMED;
                  end
               end
            end

            ST_DRAIN: begin
               if (frame_start) begin
                  filter_en   <= '0;
                  filter_sel  <= '0;
                  frames_left <= '0;
                  state       <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
